// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM input bundle and MEM->WB/EX-bypass outputs of the memory stage.
// Rev 1.0
`default_nettype none

interface mem_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              IN_VALID;
  logic [1:0]        OP_IN;
  logic [2:0]        DR_IN;
  logic [DATA_W-1:0] ALU_RES;
  logic [DATA_W-1:0] ST_DATA;
  logic              STALL;
  logic [1:0]        OP;
  logic [2:0]        DR;
  logic [DATA_W-1:0] wb_data;
  logic              FWD_EN;
  logic [2:0]        FWD_DR;
  logic [DATA_W-1:0] FWD_VAL;

  modport master (
    output IN_VALID, OP_IN, DR_IN, ALU_RES, ST_DATA,
    input  STALL, OP, DR, wb_data, FWD_EN, FWD_DR, FWD_VAL
  );

  modport slave (
    input  IN_VALID, OP_IN, DR_IN, ALU_RES, ST_DATA,
    output STALL, OP, DR, wb_data, FWD_EN, FWD_DR, FWD_VAL
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with data RAM; loads take two edges and stall upstream once.
// Rev 1.0
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  wire         CLK,
  input  wire         RST_N,
  mem_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic [1:0]        w_op_nxt;
  logic [2:0]        r_dr;
  logic [2:0]        w_dr_nxt;
  logic [DATA_W-1:0] r_wb;
  logic [DATA_W-1:0] w_wb_nxt;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;
  logic [2:0]        r_ld_dr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused_hi;

  // Address wraps modulo the RAM depth; upper ALU bits are deliberately dropped.
  assign w_addr      = bus.ALU_RES[ADDR_W-1:0];
  assign w_unused_hi = ^bus.ALU_RES[DATA_W-1:ADDR_W];

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = 2'b00;
    w_dr_nxt    = 3'd0;
    w_wb_nxt    = '0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          case (bus.OP_IN)
            2'b10: begin
              w_we     = 1'b1;
              w_op_nxt = 2'b10;
              w_dr_nxt = bus.DR_IN;
              w_wb_nxt = bus.ST_DATA;
            end
            2'b11: begin
              w_re        = 1'b1;
              w_state_nxt = S_LOAD;
            end
            default: begin
              w_op_nxt = bus.OP_IN;
              w_dr_nxt = bus.DR_IN;
              w_wb_nxt = bus.ALU_RES;
            end
          endcase
        end
      end
      S_LOAD: begin
        w_op_nxt    = 2'b11;
        w_dr_nxt    = r_ld_dr;
        w_wb_nxt    = r_rd_data;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_dr    <= 3'd0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_dr    <= w_dr_nxt;
      r_wb    <= w_wb_nxt;
    end
  end

  // RAM is not reset; a store presented on a reset edge must not land.
  always_ff @(posedge CLK) begin
    if (RST_N && w_we) begin
      r_mem[w_addr] <= bus.ST_DATA;
    end
    if (w_re) begin
      r_rd_data <= r_mem[w_addr];
      r_ld_dr   <= bus.DR_IN;
    end
  end

  assign bus.STALL   = (r_state == S_LOAD);
  assign bus.OP      = r_op;
  assign bus.DR      = r_dr;
  assign bus.wb_data = r_wb;
  assign bus.FWD_EN  = r_op[0];
  assign bus.FWD_DR  = r_dr;
  assign bus.FWD_VAL = r_wb;

endmodule

`default_nettype wire
